// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the bus countdown timer
package timer_pkg;

    // Countdown sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timer_state_e;

    // Word offsets within the register window (addr[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only the exact reload encoding reloads; 2'b1x falls back to one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped countdown timer with interrupt on the CPU data bus
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   addr   : byte address from the CPU M stage
//   wdata  : store data
//   byteen : byte enables, 4'b1111 = word write
//   rdata  : combinational read data for addr
//   irq    : interrupt request (CTRL.IM & pending flag)
module bus_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]   ctrl;
    logic [31:0]  preset;
    logic [31:0]  count;
    logic         irq_flag;
    timer_state_e state;

    logic sel;
    logic wr_en;
    logic wr_ctrl;
    logic wr_preset;
    logic unused_addr_lsb;

    // Word-aligned window; the fourth word (offset 0xc) is a hole.
    assign sel       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign wr_en     = sel && (byteen == 4'b1111);
    assign wr_ctrl   = wr_en && (addr[3:2] == REG_CTRL);
    assign wr_preset = wr_en && (addr[3:2] == REG_PRESET);

    assign unused_addr_lsb = ^addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            state    <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl[CTRL_EN]) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // PRESET of 0 lands here on the first pass, same as 1
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (is_reload(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Bus writes come last so they override any same-edge FSM update.
            if (wr_ctrl) begin
                ctrl     <= wdata[3:0];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= wdata;
                irq_flag <= 1'b0;
            end
        end
    end

    assign irq = ctrl[CTRL_IM] & irq_flag;

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                REG_CTRL:   rdata = {28'd0, ctrl};
                REG_PRESET: rdata = preset;
                REG_COUNT:  rdata = count;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - scoreboard bench for bus_timer with a timeline reference model
module tb_bus_timer;

    localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
    localparam logic [31:0] A_PRESET = 32'h0000_7f04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7f08;
    localparam logic [31:0] A_HOLE   = 32'h0000_7f0c;
    localparam logic [31:0] A_OTHER  = 32'h0000_7f14;
    localparam logic [3:0]  BE_W     = 4'b1111;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    bus_timer #(.BASE_ADDR(32'h0000_7f00)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: registers plus a timeline of edge stamps for the
    // current run (when the load happens and when the interrupt fires).
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic [31:0] m_n;
    bit          m_flag;
    bit          m_idle;
    int          m_edge;
    int          m_load_at;
    int          m_int_at;

    int t1_cnt[8] = '{0, 0, 5, 4, 3, 2, 1, 0};
    int t2_cnt[5] = '{3, 2, 1, 0, 0};

    task automatic m_reset();
        m_ctrl    = '0;
        m_preset  = '0;
        m_count   = '0;
        m_n       = '0;
        m_flag    = 1'b0;
        m_idle    = 1'b1;
        m_load_at = -10;
        m_int_at  = -10;
    endtask

    function automatic bit m_sel(input logic [31:0] a);
        return (a[31:4] == 28'h0000_7f0) && (a[3:2] != 2'b11);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (!m_sel(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_clock(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bit en;
        bit reload;
        en     = m_ctrl[0];
        reload = (m_ctrl[2:1] == 2'b01);
        if (m_idle) begin
            if (en) begin
                m_idle    = 1'b0;
                m_load_at = m_edge + 1;
            end
        end else if (m_edge == m_load_at) begin
            m_n      = m_preset;
            m_count  = m_preset;
            m_int_at = m_edge + ((m_preset > 32'd1) ? int'(m_preset) : 1);
        end else if (m_edge == m_int_at + 1) begin
            if (reload) begin
                m_flag    = 1'b0;
                m_load_at = m_edge + 1;
            end else begin
                m_ctrl[0] = 1'b0;
                m_idle    = 1'b1;
            end
        end else begin
            if (!en) begin
                m_idle = 1'b1;
            end else if (m_edge == m_int_at) begin
                m_count = '0;
                m_flag  = 1'b1;
            end else begin
                m_count = m_n - 32'(m_edge - m_load_at);
            end
        end
        if (m_sel(a) && be == 4'b1111) begin
            if (a[3:2] == 2'd0) begin
                m_ctrl = d[3:0];
                m_flag = 1'b0;
            end else if (a[3:2] == 2'd1) begin
                m_preset = d;
                m_flag   = 1'b0;
            end
        end
        m_edge++;
    endtask

    // One bus cycle: drive inputs, queue the expectation for this cycle,
    // then advance the model across the consuming edge.
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input string nm, input bit fixed,
                             input logic [31:0] exp_rd, input logic exp_irq);
        exp_t e;
        addr   = a;
        wdata  = d;
        byteen = be;
        if (!reset) m_reset();
        e.name = nm;
        if (fixed) begin
            e.rdata = exp_rd;
            e.irq   = exp_irq;
        end else begin
            e.rdata = m_rdata(a);
            e.irq   = m_ctrl[3] & m_flag;
        end
        sb.push_back(e);
        @(posedge clk);
        if (reset) m_clock(a, d, be);
        #1;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input string nm);
        bus_cycle(a, d, be, nm, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input string nm, input logic [31:0] rd, input logic ir);
        bus_cycle(a, d, be, nm, 1'b1, rd, ir);
    endtask

    // Monitor: compare away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (rdata !== e.rdata || irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                             e.name, rdata, irq, e.rdata, e.irq);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [3:0]  be;
        int          r;
        int          off;
        int          rst_hold;

        reset  = 1'b0;
        addr   = '0;
        wdata  = '0;
        byteen = '0;
        m_reset();
        m_edge = 0;
        @(posedge clk);
        #1;

        // Reset state
        chk(A_CTRL,   32'hF, BE_W, "rst_ctrl",   32'h0, 1'b0);
        chk(A_PRESET, 32'h9, BE_W, "rst_preset", 32'h0, 1'b0);
        chk(A_COUNT,  32'h0, 4'h0, "rst_count",  32'h0, 1'b0);
        reset = 1'b1;

        // 1: one-shot, PRESET=5
        chk(A_PRESET, 32'd5, BE_W, "t1_preset_wr", 32'h0, 1'b0);
        chk(A_CTRL,   32'h9, BE_W, "t1_ctrl_wr",   32'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            chk(A_COUNT, 32'h0, 4'h0, "t1_count", 32'(t1_cnt[i]), (i == 7));
        chk(A_CTRL,   32'h0, 4'h0, "t1_en_cleared", 32'h8, 1'b1);
        chk(A_COUNT,  32'h0, 4'h0, "t1_irq_held",   32'h0, 1'b1);
        chk(A_PRESET, 32'd5, BE_W, "t1_clear_wr",   32'd5, 1'b1);
        chk(A_PRESET, 32'h0, 4'h0, "t1_irq_clr",    32'd5, 1'b0);

        // 2: auto-reload, PRESET=3, period 5
        step(A_PRESET, 32'd3, BE_W, "t2_preset_wr");
        step(A_CTRL,   32'hB, BE_W, "t2_ctrl_wr");
        chk(A_COUNT, 32'h0, 4'h0, "t2_count_e0", 32'h0, 1'b0);
        chk(A_COUNT, 32'h0, 4'h0, "t2_count_e1", 32'h0, 1'b0);
        for (int i = 0; i < 15; i++)
            chk(A_COUNT, 32'h0, 4'h0, "t2_count", 32'(t2_cnt[i % 5]), ((i % 5) == 3));
        chk(A_CTRL, 32'h0, 4'h0, "t2_ctrl_kept", 32'hB, 1'b0);
        step(A_CTRL, 32'h0, BE_W, "t2_stop");
        for (int i = 0; i < 4; i++) step(A_COUNT, 32'h0, 4'h0, "t2_idle");

        // 3: masked one-shot, then flag clear via CTRL write, COUNT read-only
        step(A_PRESET, 32'd2, BE_W, "t3_preset_wr");
        step(A_CTRL,   32'h1, BE_W, "t3_ctrl_wr");
        for (int i = 0; i < 6; i++) step(A_COUNT, 32'h0, 4'h0, "t3_count");
        step(A_CTRL, 32'h8, BE_W, "t3_im_wr");
        chk(A_CTRL,  32'h0,  4'h0, "t3_flag_cleared", 32'h8, 1'b0);
        step(A_COUNT, 32'h55, BE_W, "t3_count_wr");
        chk(A_COUNT, 32'h0,  4'h0, "t3_count_ro", 32'h0, 1'b0);

        // 4: decode boundaries
        chk(A_HOLE, 32'h0, 4'h0, "t4_hole", 32'h0, 1'b0);
        step(A_PRESET, 32'hDEAD, 4'b0011, "t4_partial_wr");
        chk(A_PRESET, 32'h0, 4'h0, "t4_partial_ign", 32'd2, 1'b0);
        step(A_OTHER, 32'h77, BE_W, "t4_other_wr");
        step(32'h0000_7f10, 32'h9, BE_W, "t4_other_ctrl_wr");
        chk(A_PRESET, 32'h0, 4'h0, "t4_other_ign", 32'd2, 1'b0);
        chk(A_OTHER,  32'h0, 4'h0, "t4_other_rd",  32'h0, 1'b0);
        chk(A_CTRL + 32'd3, 32'h0, 4'h0, "t4_lsb_ign", 32'h8, 1'b0);

        // 5: CTRL write collides with one-shot INT->IDLE
        step(A_CTRL,   32'h0, BE_W, "t5_stop");
        step(A_PRESET, 32'd2, BE_W, "t5_preset_wr");
        step(A_CTRL,   32'h9, BE_W, "t5_ctrl_wr");
        for (int i = 0; i < 4; i++) step(A_COUNT, 32'h0, 4'h0, "t5_count");
        chk(A_CTRL,  32'h9, BE_W, "t5_collide_wr", 32'h9, 1'b1);
        chk(A_CTRL,  32'h0, 4'h0, "t5_ctrl_kept",  32'h9, 1'b0);
        chk(A_COUNT, 32'h0, 4'h0, "t5_load",       32'h0, 1'b0);
        chk(A_COUNT, 32'h0, 4'h0, "t5_restart",    32'd2, 1'b0);
        step(A_CTRL, 32'h0, BE_W, "t5_stop2");
        for (int i = 0; i < 3; i++) step(A_COUNT, 32'h0, 4'h0, "t5_idle");

        // 6: reset mid-count at COUNT=40
        step(A_PRESET, 32'd100, BE_W, "t6_preset_wr");
        step(A_CTRL,   32'h9,   BE_W, "t6_ctrl_wr");
        for (int i = 0; i < 200 && m_count != 32'd40; i++)
            step(A_COUNT, 32'h0, 4'h0, "t6_count");
        chk(A_COUNT, 32'h0, 4'h0, "t6_at_40", 32'd40, 1'b0);
        reset = 1'b0;
        chk(A_COUNT,  32'h0, 4'h0, "t6_rst_count",  32'h0, 1'b0);
        chk(A_CTRL,   32'h0, 4'h0, "t6_rst_ctrl",   32'h0, 1'b0);
        chk(A_PRESET, 32'h0, 4'h0, "t6_rst_preset", 32'h0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++)
            chk(A_COUNT, 32'h0, 4'h0, "t6_post_idle", 32'h0, 1'b0);

        // Randomized traffic against the model
        rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                reset    = 1'b0;
                rst_hold = $urandom_range(1, 2);
            end
            r   = $urandom_range(0, 99);
            off = $urandom_range(0, 3);
            d   = $urandom();
            be  = 4'h0;
            a   = A_CTRL + 32'(off * 4) + 32'($urandom_range(0, 3));
            if (r < 12) begin
                be = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 14)) : BE_W;
                if (off == 1) d = 32'($urandom_range(0, 6));
            end else if (r < 15) begin
                a  = 32'h0000_7f10 + 32'(off * 4);
                be = BE_W;
            end
            step(a, d, be, "rand");
        end
        reset = 1'b1;

        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
